// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and owner tags for the fetch/load-store RAM arbiter.
// Imported by the arbiter top and its grant picker.
package mem_port_arbiter_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } own_t;

  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant picker: data port first, fetch once starved.
// At most one grant is ever raised.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int IF_MAX_WAIT = 4,
  parameter int CNT_W       = 3
) (
  input  logic             if_req,
  input  logic             d_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             if_gnt,
  output logic             d_gnt
);

  logic starved;

  always_comb begin
    starved = (starve_cnt == CNT_W'(IF_MAX_WAIT));
    if_gnt  = if_req & (starved | ~d_req);
    d_gnt   = d_req & ~if_gnt;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM between fetch and load/store ports,
// routing read data back to its owner RD_LAT cycles after issue.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int IF_MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_req
);

  localparam int CNT_W = cnt_width(IF_MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IF_MAX_WAIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  own_t [RD_LAT-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic if_pick, d_pick;
  own_t push, tail;

  mem_arb_pick #(
    .IF_MAX_WAIT(IF_MAX_WAIT),
    .CNT_W      (CNT_W)
  ) u_pick (
    .if_req    (if_req),
    .d_req     (d_req),
    .starve_cnt(starve_q),
    .if_gnt    (if_pick),
    .d_gnt     (d_pick)
  );

  assign tail = tag_q[RD_LAT-1];

  always_comb begin
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_ce     = ChipDisable;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    push       = OWN_NONE;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    if_rdata   = '0;
    d_rdata    = '0;
    stall_req  = 1'b0;
    starve_d   = starve_q;
    if (rst != RstEnable) begin
      if_gnt = if_pick;
      d_gnt  = d_pick;
      unique case (1'b1)
        if_gnt: begin
          mem_ce   = ChipEnable;
          mem_addr = if_addr;
          push     = OWN_IF;
        end
        d_gnt: begin
          mem_ce    = ChipEnable;
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
          mem_wmask = d_we ? d_wmask : '0;
          push      = d_we ? OWN_NONE : OWN_D;
        end
        default: ;
      endcase
      if_rvalid = (tail == OWN_IF);
      d_rvalid  = (tail == OWN_D);
      if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
      d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
      stall_req = (if_req & ~if_gnt) | (d_req & ~d_gnt);
      // Counter only tracks data grants taken while fetch waits
      if (!if_req || if_gnt)
        starve_d = '0;
      else if (d_gnt && starve_q != CNT_MAX)
        starve_d = starve_q + CNT_W'(1);
    end
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    tag_d[0]   = push;
    for (int i = 1; i < RD_LAT; i++)
      tag_d[i] = tag_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      for (int i = 0; i < RD_LAT; i++)
        tag_q[i] <= OWN_NONE;
    end else begin
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      tag_q      <= tag_d;
    end
  end

endmodule
